// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 (reflected 0xEDB88320) over DATA_W-wide byte-enabled beats.
// GEN reports the FCS; CHECK additionally flags frames whose pre-inversion register hits the residue.
module crc32_stream #(
  parameter int DATA_W     = 8,
  parameter int CHECK_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                busy,
  output logic                crc_valid,
  output logic [31:0]         crc_out,
  output logic                crc_ok,
  output logic [CNT_W-1:0]    byte_count
);

  localparam int          LANES   = DATA_W / 8;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_crc;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_crc_out;
  logic               r_crc_ok;

  logic               w_continue;
  logic [31:0]        w_acc;
  logic [3:0]         w_pop;
  logic [CNT_W-1:0]   w_base_count;
  logic [CNT_W+3:0]   w_sum;
  logic [CNT_W-1:0]   w_next_count;

  // A beat only extends the running frame when in RUN and not being aborted;
  // otherwise it is the first beat of a fresh frame and starts from init.
  always_comb begin
    w_continue   = (r_state == RUN) && !start;
    w_acc        = w_continue ? r_crc : INIT;
    w_base_count = w_continue ? r_count : '0;
    w_pop        = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_keep[l]) begin
        w_pop = w_pop + 4'd1;
        for (int b = 0; b < 8; b++) begin
          w_acc = (w_acc[0] ^ in_data[8*l+b]) ? ((w_acc >> 1) ^ POLY) : (w_acc >> 1);
        end
      end
    end
    w_sum = {4'd0, w_base_count} + {{CNT_W{1'b0}}, w_pop};
    if (w_sum > {4'd0, {CNT_W{1'b1}}}) begin
      w_next_count = {CNT_W{1'b1}};
    end else begin
      w_next_count = w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_crc     <= INIT;
      r_count   <= '0;
      r_crc_out <= '0;
      r_crc_ok  <= 1'b0;
    end else if (in_valid) begin
      r_crc   <= w_acc;
      r_count <= w_next_count;
      if (in_last) begin
        r_state   <= DONE;
        r_crc_out <= ~w_acc;
        r_crc_ok  <= (CHECK_MODE != 0) && (w_acc == RESIDUE);
      end else begin
        r_state <= RUN;
      end
    end else if (start) begin
      r_state <= IDLE;
      r_crc   <= INIT;
      r_count <= '0;
    end else if (r_state == DONE) begin
      r_state <= IDLE;
      r_crc   <= INIT;
    end
  end

  assign busy       = (r_state == RUN);
  assign crc_valid  = (r_state == DONE);
  assign crc_out    = r_crc_out;
  assign crc_ok     = r_crc_ok;
  assign byte_count = r_count;

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: four instances (8-bit GEN, 8-bit GEN with 4-bit counter,
// 32-bit GEN, 64-bit CHECK) compared against a table-driven CRC model and a result queue.
module tb_crc32_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // group 0: 8-bit lanes, shared by u_a (CNT_W=16) and u_s (CNT_W=4)
  logic a_start, a_valid, a_last;
  logic [7:0] a_data;
  logic [0:0] a_keep;
  logic a_busy, a_cv, a_ok, s_busy, s_cv, s_ok;
  logic [31:0] a_crc, s_crc;
  logic [15:0] a_cnt;
  logic [3:0]  s_cnt;
  // group 1: 32-bit GEN
  logic b_start, b_valid, b_last;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic b_busy, b_cv, b_ok;
  logic [31:0] b_crc;
  logic [15:0] b_cnt;
  // group 2: 64-bit CHECK
  logic c_start, c_valid, c_last;
  logic [63:0] c_data;
  logic [7:0]  c_keep;
  logic c_busy, c_cv, c_ok;
  logic [31:0] c_crc;
  logic [15:0] c_cnt;

  crc32_stream #(.DATA_W(8), .CHECK_MODE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_data(a_data),
    .in_keep(a_keep), .in_last(a_last), .busy(a_busy), .crc_valid(a_cv),
    .crc_out(a_crc), .crc_ok(a_ok), .byte_count(a_cnt));
  crc32_stream #(.DATA_W(8), .CHECK_MODE(0), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_data(a_data),
    .in_keep(a_keep), .in_last(a_last), .busy(s_busy), .crc_valid(s_cv),
    .crc_out(s_crc), .crc_ok(s_ok), .byte_count(s_cnt));
  crc32_stream #(.DATA_W(32), .CHECK_MODE(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_keep(b_keep), .in_last(b_last), .busy(b_busy), .crc_valid(b_cv),
    .crc_out(b_crc), .crc_ok(b_ok), .byte_count(b_cnt));
  crc32_stream #(.DATA_W(64), .CHECK_MODE(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .in_valid(c_valid), .in_data(c_data),
    .in_keep(c_keep), .in_last(c_last), .busy(c_busy), .crc_valid(c_cv),
    .crc_out(c_crc), .crc_ok(c_ok), .byte_count(c_cnt));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] crc_tab[256];
  logic [7:0]  fb[$];
  // packed expectation: {ok, byte_count[15:0], crc[31:0]}
  logic [48:0] exp_a_q[$];
  logic [48:0] exp_b_q[$];
  logic [48:0] exp_c_q[$];
  logic [48:0] ea, eb, ec;
  logic [15:0] sat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input int m);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < m; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ fb[i]];
    return ~c;
  endfunction

  function automatic int lanes_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
  endfunction

  function automatic logic busy_of(input int g);
    return (g == 0) ? a_busy : ((g == 1) ? b_busy : c_busy);
  endfunction

  task automatic expect_res(input int g, input logic [31:0] crc, input int cnt, input logic ok);
    logic [48:0] e;
    e = {ok, 16'(cnt), crc};
    if (g == 0) exp_a_q.push_back(e);
    else if (g == 1) exp_b_q.push_back(e);
    else exp_c_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input int g, input logic st, input logic v, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
    case (g)
      0: begin a_start = st; a_valid = v; a_data = d[7:0];  a_keep = k[0:0]; a_last = l; end
      1: begin b_start = st; b_valid = v; b_data = d[31:0]; b_keep = k[3:0]; b_last = l; end
      default: begin c_start = st; c_valid = v; c_data = d; c_keep = k; c_last = l; end
    endcase
    @(posedge clk);
    #1;
    case (g)
      0: begin a_start = 1'b0; a_valid = 1'b0; a_last = 1'b0; end
      1: begin b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; end
      default: begin c_start = 1'b0; c_valid = 1'b0; c_last = 1'b0; end
    endcase
    // after a beat the frame is in progress unless that beat closed it
    if (v) chk($sformatf("g%0d_busy", g), busy_of(g), !l);
  endtask

  // Packs fb into beats lane 0 first; rnd drops lanes and inserts idle gaps.
  task automatic send_frame(input int g, input bit rnd, input bit do_last, input bit st_first);
    int lanes;
    int idx;
    bit first;
    logic [63:0] d;
    logic [7:0] k;
    logic l;
    lanes = lanes_of(g);
    idx = 0;
    first = 1'b1;
    do begin
      d = {$urandom, $urandom};
      k = '0;
      for (int ln = 0; ln < lanes; ln++) begin
        if (idx < fb.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
          k[ln] = 1'b1;
          d[8*ln +: 8] = fb[idx];
          idx++;
        end
      end
      l = do_last && (idx >= fb.size());
      drive_beat(g, st_first && first, 1'b1, d, k, l);
      first = 1'b0;
      if (rnd && !l && $urandom_range(0, 3) == 0) idle(1);
    end while (idx < fb.size());
  endtask

  task automatic load_123(input int extra);
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
    if (extra != 0) begin
      fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
    end
  endtask

  task automatic load_rand(input int n);
    fb.delete();
    repeat (n) fb.push_back(8'($urandom));
  endtask

  task automatic rand_frames(input int g, input int nfr);
    int n;
    int bi;
    bit abort;
    bit bad;
    logic [31:0] fcs;
    for (int f = 0; f < nfr; f++) begin
      abort = ($urandom_range(0, 4) == 0);
      if (abort) begin
        load_rand($urandom_range(1, 6));
        send_frame(g, 1'b1, 1'b0, 1'b0);
      end
      if (g == 2) begin
        n = $urandom_range(1, 30);
        load_rand(n);
        fcs = ref_crc(n);
        for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
        bad = ($urandom_range(0, 2) == 0);
        if (bad) begin
          bi = $urandom_range(0, n + 3);
          fb[bi] = fb[bi] ^ 8'(8'd1 << $urandom_range(0, 7));
        end
        expect_res(g, ref_crc(n + 4), n + 4, !bad);
      end else begin
        n = $urandom_range(0, (g == 0) ? 24 : 40);
        load_rand(n);
        expect_res(g, ref_crc(n), n, 1'b0);
      end
      send_frame(g, 1'b1, 1'b1, abort || ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
  endtask

  // scoreboards: every result strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (a_cv) begin
      if (exp_a_q.size() == 0) chk("a_spurious_valid", 1, 0);
      else begin
        ea = exp_a_q.pop_front();
        sat = (ea[47:32] > 16'd15) ? 16'd15 : ea[47:32];
        chk("a_crc", a_crc, ea[31:0]);
        chk("a_cnt", a_cnt, ea[47:32]);
        chk("a_ok", a_ok, 0);
        chk("s_valid", s_cv, 1);
        chk("s_crc", s_crc, ea[31:0]);
        chk("s_cnt_sat", s_cnt, sat);
      end
    end
    if (b_cv) begin
      if (exp_b_q.size() == 0) chk("b_spurious_valid", 1, 0);
      else begin
        eb = exp_b_q.pop_front();
        chk("b_crc", b_crc, eb[31:0]);
        chk("b_cnt", b_cnt, eb[47:32]);
        chk("b_ok", b_ok, 0);
      end
    end
    if (c_cv) begin
      if (exp_c_q.size() == 0) chk("c_spurious_valid", 1, 0);
      else begin
        ec = exp_c_q.pop_front();
        chk("c_crc", c_crc, ec[31:0]);
        chk("c_cnt", c_cnt, ec[47:32]);
        chk("c_ok", c_ok, ec[48]);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_out"}, {a_busy, a_cv, a_ok, a_crc, a_cnt}, 0);
    chk({tag, "_s_out"}, {s_busy, s_cv, s_ok, s_crc, s_cnt}, 0);
    chk({tag, "_b_out"}, {b_busy, b_cv, b_ok, b_crc, b_cnt}, 0);
    chk({tag, "_c_out"}, {c_busy, c_cv, c_ok, c_crc, c_cnt}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_last = 0; a_data = '0; a_keep = '0;
    b_start = 0; b_valid = 0; b_last = 0; b_data = '0; b_keep = '0;
    c_start = 0; c_valid = 0; c_last = 0; c_data = '0; c_keep = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    idle(2);

    // check value over "123456789"
    load_123(0);
    expect_res(0, 32'hCBF43926, 9, 1'b0);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    expect_res(1, 32'hCBF43926, 9, 1'b0);
    load_123(0);
    send_frame(1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("b_busy_after_done", b_busy, 0);

    // CHECK mode: good FCS, then one flipped FCS bit
    load_123(1);
    expect_res(2, 32'h2144DF1C, 13, 1'b1);
    send_frame(2, 1'b0, 1'b1, 1'b0);
    idle(1);
    load_123(1);
    fb[9] = 8'h27;
    expect_res(2, ref_crc(13), 13, 1'b0);
    send_frame(2, 1'b0, 1'b1, 1'b0);
    idle(2);

    // single-beat frame, then a back-to-back frame starting in the DONE cycle
    expect_res(0, 32'hE8B7BE43, 1, 1'b0);
    expect_res(0, 32'hD202EF8D, 1, 1'b0);
    fb.delete(); fb.push_back(8'h61);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    fb.delete(); fb.push_back(8'h00);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drive_beat(0, 1'b0, 1'b1, 64'h0, 8'h00, 1'b1);
    idle(2);

    // abort by standalone start, then by start on the first beat of the next frame
    load_rand(3);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drive_beat(0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("abort_busy", a_busy, 0);
    chk("abort_cnt", a_cnt, 0);
    load_123(0);
    expect_res(0, 32'hCBF43926, 9, 1'b0);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    idle(1);
    load_rand(3);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    load_123(0);
    expect_res(0, 32'hCBF43926, 9, 1'b0);
    send_frame(0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // saturation on the 4-bit counter, hold after the frame, clear by start
    load_rand(20);
    expect_res(0, ref_crc(20), 20, 1'b0);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("a_cnt_hold", a_cnt, 20);
    chk("s_cnt_hold", s_cnt, 15);
    drive_beat(0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("start_clr_a_cnt", a_cnt, 0);
    chk("start_clr_s_cnt", s_cnt, 0);

    // reset mid-frame discards silently
    load_rand(5);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    chk_reset_vals("midrst");
    rst = 1'b0;
    idle(4);

    rand_frames(0, 30);
    rand_frames(1, 30);
    rand_frames(2, 30);

    idle(5);
    chk("a_pending", exp_a_q.size(), 0);
    chk("b_pending", exp_b_q.size(), 0);
    chk("c_pending", exp_c_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Parametrised CRC-32 engine for the Ethernet MAC data path. Generalises the byte-serial CRC to a DATA_W-wide, byte-enabled streaming input with frame framing.
- Two modes: GEN computes the FCS for the TX path; CHECK validates a received frame, including its FCS, against the fixed residue for the RX path.
- Sits beside the MAC TX/RX framers. It observes the same beat stream the framer sends or receives and never stalls it.

Parameters:
- DATA_W, 8, input beat width in bits; legal values are 8, 16, 32, 64.
- CHECK_MODE, 0, 0 = GEN (report FCS), 1 = CHECK (report residue match).
- CNT_W, 16, width of the saturating frame byte counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; aborts any frame in progress and reloads the accumulator to init.
- in_valid  in  1  beat qualifier.
- in_data  in  DATA_W  beat data; lane 0 = in_data[7:0] is first on the wire.
- in_keep  in  DATA_W/8  per-lane byte enable.
- in_last  in  1  marks the final beat of a frame.
- busy  out  1  high while a frame is in progress (state RUN).
- crc_valid  out  1  single-cycle result strobe.
- crc_out  out  32  final FCS; crc_out[7:0] is transmitted first.
- crc_ok  out  1  CHECK mode: the residue matched. Tied 0 in GEN mode.
- byte_count  out  CNT_W  number of bytes accepted in the frame.

Behaviour:
- Algorithm: Ethernet CRC-32.
  - Reflected polynomial 0xEDB88320, right-shifting register.
  - Init 0xFFFFFFFF.
  - Each byte is processed LSB first.
  - crc_out = ~register.
- Per beat, all enabled lanes are folded within one cycle, in ascending lane order. Lanes with keep=0 are skipped; non-contiguous keep is still processed lane-by-lane in this order.
- Beats with in_valid=1 and in_keep all zero advance nothing but still honour in_last.
- No backpressure: every in_valid beat is consumed in the cycle it is presented.
- FSM states:
  - IDLE -> RUN on an in_valid beat with in_last=0. That beat is processed from init.
  - IDLE -> DONE on an in_valid beat with in_last=1, for a single-beat frame.
  - RUN -> DONE on an in_valid beat with in_last=1.
  - DONE -> IDLE unconditionally after 1 cycle.
  - DONE -> RUN if a new in_valid beat with in_last=0 arrives in the DONE cycle. That beat starts a new frame from init, so back-to-back frames run with no gap.
- Result latency: crc_valid pulses exactly 1 cycle after the in_last beat is accepted, i.e. in the DONE cycle.
  - crc_out, crc_ok and byte_count hold their values until the next frame's first beat.
- CHECK mode: crc_ok = 1 when the register after the last beat, before inversion, equals 0xDEBB20E3.
- start:
  - In any state, start forces the accumulator to init, clears byte_count, and goes to IDLE. No crc_valid is produced for the aborted frame.
  - If start and in_valid occur in the same cycle, the clear happens first and the beat is processed from init as the first beat of a new frame.
- byte_count increments by popcount(in_keep) per accepted beat and saturates at all-ones without wrapping.
- Reset values:
  - State IDLE, register 0xFFFFFFFF.
  - busy=0, crc_valid=0, crc_out=0, crc_ok=0, byte_count=0.
- Reset asserted mid-frame discards the frame silently; no crc_valid follows.
- Unused upper lanes do not exist at DATA_W=8; in_keep is 1 bit wide and behaves as a per-byte valid.

Test Plan:
- DATA_W=8, GEN, bytes "123456789" (0x31..0x39), last on 0x39 -> crc_valid 1 cycle later, crc_out=0xCBF43926, byte_count=9.
- DATA_W=32, GEN, beats 0x34333231, 0x38373635, then 0x39 with keep=0001 and in_last -> crc_out=0xCBF43926, byte_count=9, busy low after DONE.
- DATA_W=64, CHECK, "123456789" followed by 0x26 0x39 0xF4 0xCB -> crc_ok=1. The same frame with one bit of the FCS flipped -> crc_ok=0.
- DATA_W=8, single beat 0x61 with in_last -> IDLE->DONE directly, crc_out=0xE8B7BE43. A back-to-back frame of single byte 0x00 in the DONE cycle (in_last=0) followed by in_last -> second result crc_out=0xD202EF8D.
- Abort and reset:
  - start mid-frame after 3 bytes, then "123456789" -> exactly one crc_valid, with 0xCBF43926.
  - rst mid-frame -> all outputs at reset values, no crc_valid.
- Saturation: CNT_W=4, DATA_W=8, 20 bytes -> byte_count sticks at 15 and does not wrap.
